hazard_fwd_ctrl: RTL and testbench
==================================

// Module: hazard_fwd_ctrl
// PURPOSE
//  Drives the bypass and stall controls of the 5-stage MIPS pipeline. Consumes IR_D, decodes rs/rt Tuse and dest/Tnew.
//  Tracks in-flight writers through E/M/W in its own shadow pipeline registers.
//  Emits the 3-bit selects that drive the five mux_bypass instances: rsd, rtd, rse, rte and rtm.
//  Also emits the stall signal that freezes PC/IF-ID and inserts a bubble into ID/EX.
// PARAMETERS
//  REG_W   5   register index width
//  TNEW_W  2   Tnew counter width
//  SEL_W   3   bypass select width
//  RA_REG  31  jal link register
// PORTS
//  clk        in   1   rising-edge clock
//  reset_n    in   1   asynchronous reset, active low
//  ir_d       in   32  instruction currently in D
//  stall      out  1   1 = hold PC and IF/ID, bubble into ID/EX
//  sel_rsd    out  3   D-stage rs bypass select
//  sel_rtd    out  3   D-stage rt bypass select
//  sel_rse    out  3   E-stage rs bypass select
//  sel_rte    out  3   E-stage rt bypass select
//  sel_rtm    out  3   M-stage rt bypass select (sw data)
// BEHAVIOUR
//  Select encoding:
//   0 = no forward (register file or pipeline register value)
//   1 = PC8_E
//   2 = ALUOUT_M
//   3 = PC8_M
//   4 = RFWD_W
//   5..7 are unused and never driven.
//  Decode:
//   addu/subu: dest=rd, Tnew=1, Tuse rs=1, rt=1.
//   ori/lui:   dest=rt, Tnew=1, Tuse rs=1.
//   lw:        dest=rt, Tnew=2, Tuse rs=1.
//   sw:        Tuse rs=1, rt=2.
//   beq:       Tuse rs=0, rt=0.
//   bgez/jr:   Tuse rs=0.
//   jal:       dest=RA_REG, Tnew=0, kind=LINK.
//   j, nop and unknown opcodes: no use, no dest.
//   A dest of $0 is treated as no write.
//  Shadow stage record, one each for E, M and W: {valid, dest, tnew, kind(ALU/LOAD/LINK), rs, rt}.
//   Reset: all valid=0, tnew=0. Hence stall=0 and every sel=0 while reset_n is low and until the first D issue.
//   Each clk edge: W<=M, M<=E with tnew saturating-decremented (0 stays 0).
//   E<=decoded D when stall=0; E<=bubble (valid=0) when stall=1.
//  stall (combinational, same cycle as ir_d):
//   =1 if any used D source r!=0 matches a valid E or M dest with tnew > Tuse(r).
//   W is never a stall cause.
//  sel_rsd/sel_rtd:
//   Priority E(tnew==0, LINK -> 1), then M(tnew==0: ALU -> 2, LINK -> 3), then W(-> 4), else 0.
//  sel_rse/sel_rte: use the E record's rs/rt. Priority M, then W.
//  sel_rtm: uses the M record's rt. W -> 4, else 0.
//  All selects are forced to 0 when the source register is $0.
//  A match with tnew>0 in a stage does not forward and does not fall through to an older stage.
//   Such a case is covered by stall or resolves by the time of use.
//  Simultaneous stall and forward: selects are still driven for the current D operands. The CPU ignores them since D re-executes.
//  Reset asserted mid-operation: records clear asynchronously. In-flight hazards are discarded and no stall is held over.
// STRUCTURE
//  Shared package mips_defs:
//   opcode/funct constants (ADDU, SUBU, ORI, LUI, LW, SW, BEQ, BGEZ, J, JAL, JR)
//   SEL_* encodings
//   KIND_ALU/LOAD/LINK
//  Sub-module hazard_decode (combinational): ir -> {use_rs, use_rt, tuse_rs, tuse_rt, dest, tnew, kind}.
//   One instance on ir_d.
//  Top level holds the three stage records, the stall compare and the priority selects.
// TESTING
//  1. reset_n=0 while ir_d=addu $3,$1,$2 -> stall=0, all sel=0. Release reset, then one edge -> E record valid, dest=3.
//  2. addu $3,$1,$2 then addu $4,$3,$3 -> cycle 2: sel_rse=0; cycle 3 (E): sel_rse=sel_rte=2.
//  3. lw $5,0($1) then beq $5,$0 -> stall=1 for 2 cycles, then sel_rsd=4, sel_rtd=0.
//  4. lw $5 then sw $5,0($2) -> no stall; sw in M has sel_rtm=4.
//  5. jal then jr $31 -> jr in D with jal in E: stall=0, sel_rsd=1. If a delay-slot nop is between them -> sel_rsd=3.
//  6. ori $0,$1,7 then addu $2,$0,$0 -> stall=0, all sel=0. Assert reset_n=0 during a lw stall -> stall drops to 0 asynchronously.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: field widths, opcodes, bypass selects, hazard records.
package mips_defs;

   localparam int unsigned REG_W  = 5;
   localparam int unsigned TNEW_W = 2;
   localparam int unsigned TUSE_W = 2;
   localparam int unsigned SEL_W  = 3;
   localparam int unsigned OP_W   = 6;
   localparam int unsigned INSN_W = 32;

   localparam logic [REG_W-1:0] RA_REG = REG_W'(31);

   // Primary opcodes
   localparam logic [OP_W-1:0] OP_SPECIAL = 6'h00;
   localparam logic [OP_W-1:0] OP_REGIMM  = 6'h01;
   localparam logic [OP_W-1:0] OP_J       = 6'h02;
   localparam logic [OP_W-1:0] OP_JAL     = 6'h03;
   localparam logic [OP_W-1:0] OP_BEQ     = 6'h04;
   localparam logic [OP_W-1:0] OP_ORI     = 6'h0d;
   localparam logic [OP_W-1:0] OP_LUI     = 6'h0f;
   localparam logic [OP_W-1:0] OP_LW      = 6'h23;
   localparam logic [OP_W-1:0] OP_SW      = 6'h2b;

   // SPECIAL function codes and REGIMM rt selector
   localparam logic [OP_W-1:0]  FN_JR   = 6'h08;
   localparam logic [OP_W-1:0]  FN_ADDU = 6'h21;
   localparam logic [OP_W-1:0]  FN_SUBU = 6'h23;
   localparam logic [REG_W-1:0] RT_BGEZ = 5'h01;

   // Bypass mux select encodings; 5..7 are never produced
   localparam logic [SEL_W-1:0] SEL_NONE     = 3'd0;
   localparam logic [SEL_W-1:0] SEL_PC8_E    = 3'd1;
   localparam logic [SEL_W-1:0] SEL_ALUOUT_M = 3'd2;
   localparam logic [SEL_W-1:0] SEL_PC8_M    = 3'd3;
   localparam logic [SEL_W-1:0] SEL_RFWD_W   = 3'd4;

   typedef enum logic [1:0] {
      KIND_ALU  = 2'd0,
      KIND_LOAD = 2'd1,
      KIND_LINK = 2'd2
   } kind_e;

   // Decoded D-stage instruction; rs/rt are zeroed when the operand is not read
   typedef struct packed {
      logic              use_rs;
      logic              use_rt;
      logic [TUSE_W-1:0] tuse_rs;
      logic [TUSE_W-1:0] tuse_rt;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  dest;
      logic [TNEW_W-1:0] tnew;
      kind_e             kind;
   } dec_t;

   // Shadow record of one in-flight instruction in E, M or W
   typedef struct packed {
      logic              valid;
      logic [REG_W-1:0]  dest;
      logic [TNEW_W-1:0] tnew;
      kind_e             kind;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
   } stage_rec_t;

   localparam stage_rec_t REC_BUBBLE = '{
      valid : 1'b0,
      dest  : '0,
      tnew  : '0,
      kind  : KIND_ALU,
      rs    : '0,
      rt    : '0
   };

   // Tnew counts down one per stage advance and holds at zero
   function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
      return (t == '0) ? TNEW_W'(0) : t - TNEW_W'(1);
   endfunction

endpackage

// File: rtl/hazard_decode.sv
// Combinational decode of one instruction into operand-use timing and writer info.
module hazard_decode
   import mips_defs::*;
(
   input  logic [INSN_W-1:0] ir,
   output dec_t              dec
);

   logic [OP_W-1:0]  w_op;
   logic [OP_W-1:0]  w_funct;
   logic [REG_W-1:0] w_rs;
   logic [REG_W-1:0] w_rt;
   logic [REG_W-1:0] w_rd;
   logic             w_unused_shamt;

   assign w_op           = ir[31:26];
   assign w_rs           = ir[25:21];
   assign w_rt           = ir[20:16];
   assign w_rd           = ir[15:11];
   assign w_funct        = ir[5:0];
   assign w_unused_shamt = ^ir[10:6];

   // Opcode table: which sources are read when, and what gets written when
   always_comb begin
      dec      = '0;
      dec.kind = KIND_ALU;
      case (w_op)
         OP_SPECIAL: begin
            case (w_funct)
               FN_ADDU, FN_SUBU: begin
                  dec.use_rs  = 1'b1;
                  dec.use_rt  = 1'b1;
                  dec.tuse_rs = TUSE_W'(1);
                  dec.tuse_rt = TUSE_W'(1);
                  dec.dest    = w_rd;
                  dec.tnew    = TNEW_W'(1);
               end
               FN_JR: begin
                  dec.use_rs  = 1'b1;
                  dec.tuse_rs = TUSE_W'(0);
               end
               default: ;
            endcase
         end
         OP_ORI, OP_LUI: begin
            dec.use_rs  = 1'b1;
            dec.tuse_rs = TUSE_W'(1);
            dec.dest    = w_rt;
            dec.tnew    = TNEW_W'(1);
         end
         OP_LW: begin
            dec.use_rs  = 1'b1;
            dec.tuse_rs = TUSE_W'(1);
            dec.dest    = w_rt;
            dec.tnew    = TNEW_W'(2);
            dec.kind    = KIND_LOAD;
         end
         OP_SW: begin
            dec.use_rs  = 1'b1;
            dec.use_rt  = 1'b1;
            dec.tuse_rs = TUSE_W'(1);
            dec.tuse_rt = TUSE_W'(2);
         end
         OP_BEQ: begin
            dec.use_rs  = 1'b1;
            dec.use_rt  = 1'b1;
            dec.tuse_rs = TUSE_W'(0);
            dec.tuse_rt = TUSE_W'(0);
         end
         OP_REGIMM: begin
            if (w_rt == RT_BGEZ) begin
               dec.use_rs  = 1'b1;
               dec.tuse_rs = TUSE_W'(0);
            end
         end
         OP_JAL: begin
            dec.dest = RA_REG;
            dec.tnew = TNEW_W'(0);
            dec.kind = KIND_LINK;
         end
         default: ;
      endcase
      // Unread operands look like $0 so they never match a writer
      dec.rs = dec.use_rs ? w_rs : REG_W'(0);
      dec.rt = dec.use_rt ? w_rt : REG_W'(0);
   end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Stall and bypass-select generation for the 5-stage MIPS pipeline.
// Keeps shadow E/M/W writer records and compares them against D, E and M operands.
module hazard_fwd_ctrl
   import mips_defs::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic [INSN_W-1:0] ir_d,
   output logic              stall,
   output logic [SEL_W-1:0]  sel_rsd,
   output logic [SEL_W-1:0]  sel_rtd,
   output logic [SEL_W-1:0]  sel_rse,
   output logic [SEL_W-1:0]  sel_rte,
   output logic [SEL_W-1:0]  sel_rtm
);

   dec_t       w_dec;
   stage_rec_t w_issue;
   stage_rec_t w_e_adv;
   stage_rec_t r_e;
   stage_rec_t r_m;
   stage_rec_t r_w;
   logic       w_stall_rs;
   logic       w_stall_rt;
   logic       w_stall;
   logic       w_unused_rec;

   // A live writer of register r ($0 is never a writer)
   function automatic logic hit(input stage_rec_t rec, input logic [REG_W-1:0] r);
      return rec.valid && (r != '0) && (rec.dest == r);
   endfunction

   // Writer in rec still too young for a consumer needing r at tuse
   function automatic logic too_late(input stage_rec_t rec, input logic [REG_W-1:0] r,
                                     input logic [TUSE_W-1:0] tuse);
      return hit(rec, r) && (rec.tnew > tuse);
   endfunction

   // M/W forwarding chain; a young match in M blocks the older W value
   function automatic logic [SEL_W-1:0] sel_mw(input logic [REG_W-1:0] r,
                                               input stage_rec_t m, input stage_rec_t w);
      logic [SEL_W-1:0] s;
      s = SEL_NONE;
      if (hit(m, r)) begin
         if (m.tnew == '0) begin
            if (m.kind == KIND_LINK)
               s = SEL_PC8_M;
            else if (m.kind == KIND_ALU)
               s = SEL_ALUOUT_M;
         end
      end else if (hit(w, r)) begin
         s = SEL_RFWD_W;
      end
      return s;
   endfunction

   // D-stage chain: only a ready jal in E forwards, otherwise fall to M/W
   function automatic logic [SEL_W-1:0] sel_emw(input logic [REG_W-1:0] r, input stage_rec_t e,
                                                input stage_rec_t m, input stage_rec_t w);
      logic [SEL_W-1:0] s;
      s = SEL_NONE;
      if (hit(e, r)) begin
         if ((e.tnew == '0) && (e.kind == KIND_LINK))
            s = SEL_PC8_E;
      end else begin
         s = sel_mw(r, m, w);
      end
      return s;
   endfunction

   hazard_decode u_decode (
      .ir  (ir_d),
      .dec (w_dec)
   );

   // Record for the D instruction entering E, and the E record aged into M
   always_comb begin
      w_issue       = REC_BUBBLE;
      w_issue.valid = 1'b1;
      w_issue.dest  = w_dec.dest;
      w_issue.tnew  = w_dec.tnew;
      w_issue.kind  = w_dec.kind;
      w_issue.rs    = w_dec.rs;
      w_issue.rt    = w_dec.rt;
      w_e_adv       = r_e;
      w_e_adv.tnew  = tnew_dec(r_e.tnew);
   end

   // Stall when a D source is produced too late by a writer in E or M
   always_comb begin
      w_stall_rs = 1'b0;
      w_stall_rt = 1'b0;
      if (w_dec.use_rs)
         w_stall_rs = too_late(r_e, w_dec.rs, w_dec.tuse_rs) ||
                      too_late(r_m, w_dec.rs, w_dec.tuse_rs);
      if (w_dec.use_rt)
         w_stall_rt = too_late(r_e, w_dec.rt, w_dec.tuse_rt) ||
                      too_late(r_m, w_dec.rt, w_dec.tuse_rt);
      w_stall = w_stall_rs || w_stall_rt;
   end

   // Shadow pipeline advance; a stalled D leaves a bubble in E
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_e <= REC_BUBBLE;
         r_m <= REC_BUBBLE;
         r_w <= REC_BUBBLE;
      end else begin
         r_w <= r_m;
         r_m <= w_e_adv;
         r_e <= w_stall ? REC_BUBBLE : w_issue;
      end
   end

   assign stall   = w_stall;
   assign sel_rsd = sel_emw(w_dec.rs, r_e, r_m, r_w);
   assign sel_rtd = sel_emw(w_dec.rt, r_e, r_m, r_w);
   assign sel_rse = sel_mw(r_e.rs, r_m, r_w);
   assign sel_rte = sel_mw(r_e.rt, r_m, r_w);
   assign sel_rtm = hit(r_w, r_m.rt) ? SEL_RFWD_W : SEL_NONE;

   // Record fields that no comparison needs
   assign w_unused_rec = ^{r_m.rs, r_w.tnew, r_w.kind, r_w.rs, r_w.rt};

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed vector bench for hazard_fwd_ctrl: one row per D-stage cycle.
module tb_hazard_fwd_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] ir_d;
   logic        stall;
   logic [2:0]  sel_rsd, sel_rtd, sel_rse, sel_rte, sel_rtm;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [31:0] ir;
      logic        st;
      logic [2:0]  rsd;
      logic [2:0]  rtd;
      logic [2:0]  rse;
      logic [2:0]  rte;
      logic [2:0]  rtm;
   } vec_t;

   vec_t vecs[$];

   hazard_fwd_ctrl dut (
      .clk     (clk),
      .reset_n (reset_n),
      .ir_d    (ir_d),
      .stall   (stall),
      .sel_rsd (sel_rsd),
      .sel_rtd (sel_rtd),
      .sel_rse (sel_rse),
      .sel_rte (sel_rte),
      .sel_rtm (sel_rtm)
   );

   always #5 clk = ~clk;

   // Instruction encoders
   function automatic logic [31:0] e_addu(int rd, int rs, int rt);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'h21};
   endfunction
   function automatic logic [31:0] e_subu(int rd, int rs, int rt);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'h23};
   endfunction
   function automatic logic [31:0] e_ori(int rt, int rs, int imm);
      return {6'h0d, 5'(rs), 5'(rt), 16'(imm)};
   endfunction
   function automatic logic [31:0] e_lui(int rt, int imm);
      return {6'h0f, 5'h00, 5'(rt), 16'(imm)};
   endfunction
   function automatic logic [31:0] e_lw(int rt, int base, int off);
      return {6'h23, 5'(base), 5'(rt), 16'(off)};
   endfunction
   function automatic logic [31:0] e_sw(int rt, int base, int off);
      return {6'h2b, 5'(base), 5'(rt), 16'(off)};
   endfunction
   function automatic logic [31:0] e_beq(int rs, int rt);
      return {6'h04, 5'(rs), 5'(rt), 16'h0002};
   endfunction
   function automatic logic [31:0] e_bgez(int rs);
      return {6'h01, 5'(rs), 5'h01, 16'h0003};
   endfunction
   function automatic logic [31:0] e_jr(int rs);
      return {6'h00, 5'(rs), 15'h0000, 6'h08};
   endfunction
   function automatic logic [31:0] e_jal();
      return {6'h03, 26'h0000040};
   endfunction
   function automatic logic [31:0] e_j();
      return {6'h02, 26'h0000080};
   endfunction

   localparam logic [31:0] NOP = 32'h0000_0000;

   task automatic add(input logic [31:0] ir, input logic st, input int a, input int b,
                      input int c, input int d, input int e);
      vec_t v;
      v.ir  = ir;
      v.st  = st;
      v.rsd = 3'(a);
      v.rtd = 3'(b);
      v.rse = 3'(c);
      v.rte = 3'(d);
      v.rtm = 3'(e);
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int row, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s row %0d: got %0d, want %0d", name, row, act, exp);
      end
   endtask

   task automatic chk_all(input int row, input vec_t v);
      chk("stall",   row, int'(stall),   int'(v.st));
      chk("sel_rsd", row, int'(sel_rsd), int'(v.rsd));
      chk("sel_rtd", row, int'(sel_rtd), int'(v.rtd));
      chk("sel_rse", row, int'(sel_rse), int'(v.rse));
      chk("sel_rte", row, int'(sel_rte), int'(v.rte));
      chk("sel_rtm", row, int'(sel_rtm), int'(v.rtm));
   endtask

   initial begin
      vec_t zero;
      // Rows follow the reset release with addu $3,$1,$2 issued into E
      add(e_beq(3, 0),      1, 0, 0, 0, 0, 0);   // addu $3 in E, young -> stall
      add(e_beq(3, 0),      0, 2, 0, 0, 0, 0);   // addu $3 in M -> ALUOUT_M
      add(e_addu(3, 1, 2),  0, 0, 0, 4, 0, 0);   // beq in E, addu $3 in W
      add(e_addu(4, 3, 3),  0, 0, 0, 0, 0, 0);   // addu $3 in E, Tnew==Tuse: no stall
      add(NOP,              0, 0, 0, 2, 2, 0);   // addu $4 in E sees $3 in M
      add(NOP,              0, 0, 0, 0, 0, 4);   // addu $4 in M, rt=$3 in W
      add(NOP,              0, 0, 0, 0, 0, 0);
      add(e_lw(5, 1, 0),    0, 0, 0, 0, 0, 0);
      add(e_beq(5, 0),      1, 0, 0, 0, 0, 0);   // lw in E
      add(e_beq(5, 0),      1, 0, 0, 0, 0, 0);   // lw in M, still young
      add(e_beq(5, 0),      0, 4, 0, 0, 0, 0);   // lw in W
      add(NOP,              0, 0, 0, 0, 0, 0);
      add(NOP,              0, 0, 0, 0, 0, 0);
      add(e_lw(5, 1, 0),    0, 0, 0, 0, 0, 0);
      add(e_sw(5, 2, 0),    0, 0, 0, 0, 0, 0);   // sw data needed late: no stall
      add(NOP,              0, 0, 0, 0, 0, 0);   // sw in E, lw in M young: no forward
      add(NOP,              0, 0, 0, 0, 0, 4);   // sw in M, lw in W
      add(NOP,              0, 0, 0, 0, 0, 0);
      add(e_jal(),          0, 0, 0, 0, 0, 0);
      add(e_jr(31),         0, 1, 0, 0, 0, 0);   // jal in E -> PC8_E
      add(NOP,              0, 0, 0, 3, 0, 0);   // jr in E, jal in M
      add(NOP,              0, 0, 0, 0, 0, 0);
      add(e_jal(),          0, 0, 0, 0, 0, 0);
      add(NOP,              0, 0, 0, 0, 0, 0);   // delay slot
      add(e_jr(31),         0, 3, 0, 0, 0, 0);   // jal in M -> PC8_M
      add(NOP,              0, 0, 0, 4, 0, 0);   // jr in E, jal in W
      add(NOP,              0, 0, 0, 0, 0, 0);
      add(e_ori(0, 1, 7),   0, 0, 0, 0, 0, 0);
      add(e_addu(2, 0, 0),  0, 0, 0, 0, 0, 0);   // $0 never forwarded or stalled
      add(NOP,              0, 0, 0, 0, 0, 0);
      add(e_lui(7, 16'h1234), 0, 0, 0, 0, 0, 0);
      add(e_bgez(7),        1, 0, 0, 0, 0, 0);
      add(e_bgez(7),        0, 2, 0, 0, 0, 0);
      add(e_subu(8, 7, 7),  0, 4, 4, 4, 0, 0);
      add(e_j(),            0, 0, 0, 0, 0, 0);
      add(e_sw(8, 8, 4),    0, 2, 2, 0, 0, 0);
      add(NOP,              0, 0, 0, 4, 4, 0);
      add(NOP,              0, 0, 0, 0, 0, 0);
      add(e_addu(10, 1, 2), 0, 0, 0, 0, 0, 0);
      add(e_lw(9, 3, 0),    0, 0, 0, 0, 0, 0);
      add(e_addu(11, 9, 10), 1, 0, 2, 0, 0, 0);  // stall plus rt forward together
      add(e_addu(11, 9, 10), 0, 0, 4, 0, 0, 0);  // lw in M blocks W fall-through
      add(NOP,              0, 0, 0, 4, 0, 0);

      zero = '0;

      // Reset held: everything quiet even with a writer in D
      reset_n = 1'b0;
      ir_d    = e_addu(3, 1, 2);
      repeat (2) @(negedge clk);
      #1;
      chk_all(-1, zero);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk_all(-2, zero);

      foreach (vecs[i]) begin
         @(negedge clk);
         ir_d = vecs[i].ir;
         #1;
         chk_all(i, vecs[i]);
      end

      // Reset during a load-use stall drops stall asynchronously
      @(negedge clk);
      ir_d = e_lw(5, 1, 0);
      @(negedge clk);
      ir_d = e_beq(5, 0);
      #1;
      chk("mid_stall_before", 0, int'(stall), 1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("mid_stall_async", 0, int'(stall), 0);
      chk("mid_rsd_async",   0, int'(sel_rsd), 0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("mid_after_release", 0, int'(stall), 0);
      @(negedge clk);
      #1;
      chk("mid_no_holdover", 0, int'(stall), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: bench did not finish, got timeout, want completion");
      $fatal(1);
   end

endmodule
